datapath_ctrl: RTL and testbench

- Multi-cycle control unit that sequences the 8-register / ALU / G-register datapath over its shared 16-bit bus.
- Accepts one 9-bit instruction per run handshake and drives every datapath enable cycle by cycle until the instruction retires.
- Guarantees at most one bus driver per cycle.
- Sits between the instruction source (test bench or future fetch unit) and the datapath control inputs.

---
 rtl/datapath_ctrl_pkg.sv | 39 +++
 rtl/datapath_ctrl_dec_onehot.sv | 27 ++
 rtl/datapath_ctrl.sv | 148 ++++++++++++++
 tb/tb_datapath_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// datapath_ctrl_pkg
// Shared definitions for the datapath sequencer: opcode values, FSM state
// encoding, ALU select values, instruction field positions and a small opcode
// classification helper.
// -----------------------------------------------------------------------------
package datapath_ctrl_pkg;

  // Instruction layout: {op[8:6], rx[5:3], ry[2:0]}
  localparam int INSTR_REG_SEL_W = 3;
  localparam int INSTR_OP_W      = 3;
  localparam int RY_LSB          = 0;
  localparam int RX_LSB          = 3;
  localparam int OP_LSB          = 6;

  // Opcodes; 100..111 are unsupported
  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  // ALU operation select
  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  // Sequencer states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_T1   = 2'd1,
    S_T2   = 2'd2,
    S_T3   = 2'd3
  } state_t;

  // True for the two opcodes that need the three-step ALU sequence
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/datapath_ctrl_dec_onehot.sv
// -----------------------------------------------------------------------------
// dec_onehot
// Binary-to-one-hot decoder with enable. When en is low the output is all
// zeros, so a disabled decoder never selects a register.
//   en     : decode enable
//   sel    : binary select, SEL_W bits
//   onehot : one-hot (or zero) result, 2**SEL_W bits
// -----------------------------------------------------------------------------
module dec_onehot #(
  parameter int SEL_W = 3
) (
  input  logic                  en,
  input  logic [SEL_W-1:0]      sel,
  output logic [2**SEL_W-1:0]   onehot
);

  // Decode sel into a single set bit, gated by en
  always_comb begin
    onehot = {(2**SEL_W){1'b0}};
    if (en) begin
      onehot[sel] = 1'b1;
    end else begin
      onehot = {(2**SEL_W){1'b0}};
    end
  end

endmodule

// File: rtl/datapath_ctrl.sv
// -----------------------------------------------------------------------------
// datapath_ctrl
// Multi-cycle sequencer for the 8-register / ALU / G-register datapath that
// shares one 16-bit bus. One instruction is accepted per run handshake in
// IDLE; every datapath enable is then driven cycle by cycle until done.
// All enables decode combinationally from the state and instruction
// registers, so an asynchronous reset clears them without waiting for a clock.
//   clk, reset   : clock, asynchronous active-high reset
//   run, instr   : start request and {op, rx, ry}, sampled only in IDLE
//   busy, done   : sequencer active / final-cycle pulse
//   illegal      : pulses with done for unsupported opcodes
//   ext_data_en, reg_out_en, alu_out_en : bus drivers (at most one active)
//   reg_in_en, alu_reg_en, g_reg_en     : register load enables
//   alu_sel      : 0 add, 1 sub (only meaningful in T2)
// -----------------------------------------------------------------------------
module datapath_ctrl
  import datapath_ctrl_pkg::*;
#(
  parameter int REG_SEL_W = INSTR_REG_SEL_W,
  parameter int OP_W      = INSTR_OP_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          run,
  input  logic [OP_W+2*REG_SEL_W-1:0]   instr,
  output logic                          busy,
  output logic                          done,
  output logic                          illegal,
  output logic                          ext_data_en,
  output logic [2**REG_SEL_W-1:0]       reg_in_en,
  output logic [2**REG_SEL_W-1:0]       reg_out_en,
  output logic                          alu_reg_en,
  output logic                          alu_sel,
  output logic                          alu_out_en,
  output logic                          g_reg_en
);

  state_t                         state_r;
  logic [OP_W+2*REG_SEL_W-1:0]    ir_r;

  logic [OP_W-1:0]                op_s;
  logic [REG_SEL_W-1:0]           rx_s;
  logic [REG_SEL_W-1:0]           ry_s;
  logic                           in_en_s;
  logic                           out_en_s;
  logic [REG_SEL_W-1:0]           out_sel_s;

  assign op_s = ir_r[OP_LSB +: OP_W];
  assign rx_s = ir_r[RX_LSB +: REG_SEL_W];
  assign ry_s = ir_r[RY_LSB +: REG_SEL_W];

  // Sequencer state and instruction register; IR only loads on acceptance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      ir_r    <= {(OP_W+2*REG_SEL_W){1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (run) begin
            ir_r    <= instr;
            state_r <= S_T1;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_T1: begin
          if (is_arith(op_s)) begin
            state_r <= S_T2;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_T2:    state_r <= S_T3;
        S_T3:    state_r <= S_IDLE;
        default: state_r <= S_IDLE;
      endcase
    end
  end

  // Per-state enable decode; every path leaves at most one bus driver active
  always_comb begin
    done        = 1'b0;
    illegal     = 1'b0;
    ext_data_en = 1'b0;
    alu_reg_en  = 1'b0;
    alu_sel     = ALU_ADD;
    alu_out_en  = 1'b0;
    g_reg_en    = 1'b0;
    in_en_s     = 1'b0;
    out_en_s    = 1'b0;
    out_sel_s   = ry_s;
    case (state_r)
      S_T1: begin
        case (op_s)
          OP_MV: begin
            out_en_s = 1'b1;
            in_en_s  = 1'b1;
            done     = 1'b1;
          end
          OP_MVI: begin
            ext_data_en = 1'b1;
            in_en_s     = 1'b1;
            done        = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            // First operand (rx) is latched into the ALU A register
            out_sel_s  = rx_s;
            out_en_s   = 1'b1;
            alu_reg_en = 1'b1;
          end
          default: begin
            done    = 1'b1;
            illegal = 1'b1;
          end
        endcase
      end
      S_T2: begin
        out_en_s = 1'b1;
        g_reg_en = 1'b1;
        alu_sel  = (op_s == OP_SUB) ? ALU_SUB : ALU_ADD;
      end
      S_T3: begin
        alu_out_en = 1'b1;
        in_en_s    = 1'b1;
        done       = 1'b1;
      end
      default: begin
        done = 1'b0;
      end
    endcase
  end

  assign busy = (state_r != S_IDLE);

  dec_onehot #(.SEL_W(REG_SEL_W)) u_in_dec (
    .en     (in_en_s),
    .sel    (rx_s),
    .onehot (reg_in_en)
  );

  dec_onehot #(.SEL_W(REG_SEL_W)) u_out_dec (
    .en     (out_en_s),
    .sel    (out_sel_s),
    .onehot (reg_out_en)
  );

endmodule

// File: tb/tb_datapath_ctrl.sv
// -----------------------------------------------------------------------------
// tb_datapath_ctrl
// Bench for datapath_ctrl with a behavioural datapath attached to its enables.
// Expected control vectors are queued per issued instruction and popped one
// per cycle; a reference register file tracks architectural results.
// -----------------------------------------------------------------------------
module tb_datapath_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [8:0]  instr;
  logic        busy, done, illegal, ext_data_en, alu_reg_en, alu_sel, alu_out_en, g_reg_en;
  logic [7:0]  reg_in_en, reg_out_en;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       illegal;
    logic       ext;
    logic [7:0] in_en;
    logic [7:0] out_en;
    logic       alu_reg;
    logic       alu_sel;
    logic       alu_out;
    logic       g;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '0;

  ctl_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  logic [15:0] ext_data;
  logic [15:0] dp_regs[8];
  logic [15:0] dp_a, dp_g, bus;
  logic [15:0] ref_regs[8];

  datapath_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .instr       (instr),
    .busy        (busy),
    .done        (done),
    .illegal     (illegal),
    .ext_data_en (ext_data_en),
    .reg_in_en   (reg_in_en),
    .reg_out_en  (reg_out_en),
    .alu_reg_en  (alu_reg_en),
    .alu_sel     (alu_sel),
    .alu_out_en  (alu_out_en),
    .g_reg_en    (g_reg_en)
  );

  always #5 clk = ~clk;

  // Behavioural datapath: shared bus plus register file, A and G
  always_comb begin
    bus = 16'h0000;
    if (ext_data_en) bus = ext_data;
    else if (alu_out_en) bus = dp_g;
    else begin
      for (int i = 0; i < 8; i++) if (reg_out_en[i]) bus = dp_regs[i];
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) dp_regs[i] <= 16'h0000;
      dp_a <= 16'h0000;
      dp_g <= 16'h0000;
    end else begin
      for (int i = 0; i < 8; i++) if (reg_in_en[i]) dp_regs[i] <= bus;
      if (alu_reg_en) dp_a <= bus;
      if (g_reg_en) dp_g <= alu_sel ? (dp_a - bus) : (dp_a + bus);
    end
  end

  // Per-cycle invariants: single bus driver, one-hot enables, done only while busy
  always @(negedge clk) begin
    if (!reset) begin
      int drivers;
      drivers = $countones(reg_out_en) + int'(ext_data_en) + int'(alu_out_en);
      vectors++;
      if (drivers > 1 || !$onehot0(reg_in_en) || !$onehot0(reg_out_en) || (done && !busy)) begin
        miscompares++;
        $display("FAIL invariant t=%0t: drivers=%0d in=%b out=%b done=%b busy=%b (required <=1 driver, one-hot, done only when busy)",
                 $time, drivers, reg_in_en, reg_out_en, done, busy);
      end
    end
  end

  function automatic ctl_t sample();
    ctl_t c;
    c.busy = busy; c.done = done; c.illegal = illegal; c.ext = ext_data_en;
    c.in_en = reg_in_en; c.out_en = reg_out_en; c.alu_reg = alu_reg_en;
    c.alu_sel = alu_sel; c.alu_out = alu_out_en; c.g = g_reg_en;
    return c;
  endfunction

  // Queue the cycle-by-cycle control vectors an instruction must produce
  function automatic void push_expect(input logic [8:0] ins);
    logic [2:0] op, rx, ry;
    logic [7:0] hx, hy;
    ctl_t c;
    op = ins[8:6]; rx = ins[5:3]; ry = ins[2:0];
    hx = 8'b0000_0001 << rx;
    hy = 8'b0000_0001 << ry;
    c = CTL_IDLE; c.busy = 1'b1;
    case (op)
      3'b000: begin c.done = 1'b1; c.in_en = hx; c.out_en = hy; exp_q.push_back(c); end
      3'b001: begin c.done = 1'b1; c.in_en = hx; c.ext = 1'b1; exp_q.push_back(c); end
      3'b010, 3'b011: begin
        c.out_en = hx; c.alu_reg = 1'b1; exp_q.push_back(c);
        c = CTL_IDLE; c.busy = 1'b1; c.out_en = hy; c.g = 1'b1; c.alu_sel = op[0]; exp_q.push_back(c);
        c = CTL_IDLE; c.busy = 1'b1; c.alu_out = 1'b1; c.in_en = hx; c.done = 1'b1; exp_q.push_back(c);
      end
      default: begin c.done = 1'b1; c.illegal = 1'b1; exp_q.push_back(c); end
    endcase
    exp_q.push_back(CTL_IDLE);
  endfunction

  // Architectural effect of one instruction on the reference register file
  function automatic void ref_update(input logic [8:0] ins, input logic [15:0] ed);
    logic [2:0] rx, ry;
    rx = ins[5:3]; ry = ins[2:0];
    case (ins[8:6])
      3'b000:  ref_regs[rx] = ref_regs[ry];
      3'b001:  ref_regs[rx] = ed;
      3'b010:  ref_regs[rx] = ref_regs[rx] + ref_regs[ry];
      3'b011:  ref_regs[rx] = ref_regs[rx] - ref_regs[ry];
      default: ref_regs[rx] = ref_regs[rx];
    endcase
  endfunction

  // Issue one instruction from an IDLE negedge and check every cycle to IDLE
  task automatic run_instr(input logic [8:0] ins, input logic [15:0] ed, input bit poke, input string nm);
    ctl_t e, o;
    int   n;
    ext_data = ed; run = 1'b1; instr = ins;
    push_expect(ins);
    ref_update(ins, ed);
    n = 0;
    while (exp_q.size() > 0 && n < 8) begin
      @(negedge clk);
      if (n == 0) begin run = 1'b0; instr = 9'($urandom); end
      if (poke && n == 1) begin run = 1'b1; instr = 9'b000_000_001; end
      if (poke && n == 2) run = 1'b0;
      e = exp_q.pop_front();
      o = sample();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL %s cycle %0d: got %h required %h", nm, n, o, e);
      end
      n++;
    end
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL %s timeout: %0d vectors left, required 0", nm, exp_q.size());
      exp_q.delete();
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (dp_regs[i] !== ref_regs[i]) begin
        miscompares++;
        $display("FAIL %s R%0d: got %h required %h", nm, i, dp_regs[i], ref_regs[i]);
      end
    end
  endtask

  task automatic idle_cycles(input int n, input string nm);
    ctl_t o;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      o = sample();
      vectors++;
      if (o !== CTL_IDLE) begin
        miscompares++;
        $display("FAIL %s idle: got %h required %h", nm, o, CTL_IDLE);
      end
    end
  endtask

  task automatic test_reset();
    ctl_t o;
    reset = 1'b1; run = 1'b0; instr = 9'h000; ext_data = 16'h0000;
    for (int i = 0; i < 8; i++) ref_regs[i] = 16'h0000;
    #1;
    o = sample();
    vectors++;
    if (o !== CTL_IDLE) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h required %h", o, CTL_IDLE);
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    idle_cycles(2, "reset_release");
  endtask

  task automatic test_mvi();
    run_instr(9'b001_011_000, 16'h1234, 1'b0, "mvi");
  endtask

  task automatic test_mv();
    run_instr(9'b000_101_011, 16'h0000, 1'b0, "mv");
  endtask

  task automatic test_add();
    run_instr(9'b001_001_000, 16'd5, 1'b0, "add_load_r1");
    run_instr(9'b001_010_000, 16'd7, 1'b0, "add_load_r2");
    run_instr(9'b010_001_010, 16'h0000, 1'b0, "add");
    vectors++;
    if (dp_regs[1] !== 16'd12) begin
      miscompares++;
      $display("FAIL add_result: got %0d required 12", dp_regs[1]);
    end
  endtask

  task automatic test_sub_same_busy_run();
    run_instr(9'b001_100_000, 16'd9, 1'b0, "sub_load_r4");
    run_instr(9'b011_100_100, 16'h0000, 1'b1, "sub_same_poke");
    vectors++;
    if (dp_regs[4] !== 16'd0) begin
      miscompares++;
      $display("FAIL sub_same_result: got %0d required 0", dp_regs[4]);
    end
  endtask

  task automatic test_illegal();
    run_instr(9'b110_000_000, 16'h0000, 1'b0, "illegal");
    run_instr(9'b111_111_111, 16'h0000, 1'b0, "illegal_111");
  endtask

  task automatic test_async_reset();
    ctl_t o;
    run = 1'b1; instr = 9'b010_001_010;
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    vectors++;
    if (g_reg_en !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL async_pre_t2: got g_reg_en=%b busy=%b required 1 1", g_reg_en, busy);
    end
    #2 reset = 1'b1;
    #1 o = sample();
    vectors++;
    if (o !== CTL_IDLE) begin
      miscompares++;
      $display("FAIL async_reset_immediate: got %h required %h", o, CTL_IDLE);
    end
    for (int i = 0; i < 8; i++) ref_regs[i] = 16'h0000;
    @(negedge clk);
    reset = 1'b0;
    idle_cycles(2, "async_reset_release");
  endtask

  task automatic test_random();
    for (int k = 0; k < 1000; k++) begin
      run_instr(9'($urandom), 16'($urandom), 1'b0, "random");
      idle_cycles(int'($urandom_range(0, 3)), "random_gap");
    end
  endtask

  initial begin
    test_reset();
    test_mvi();
    test_mv();
    test_add();
    test_sub_same_busy_run();
    test_illegal();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
